// File: rtl/alu_pkg.sv
// Shared ALU select codes, flag bit positions and arbiter FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_HOLD  = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_NOT   = 4'b0111;
    localparam logic [3:0] ALU_XOR   = 4'b1000;
    localparam logic [3:0] ALU_SHL   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    localparam int FLAG_C  = 0;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_OV = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter: round-robin when ALU_ARB_RR_EN is defined,
// otherwise fixed priority with port 0 winning ties.
module rr_arb2 (
    input  logic [1:0] i_req,
`ifdef ALU_ARB_RR_EN
    input  logic       i_last,
`endif
    output logic [1:0] o_grant
);

`ifdef ALU_ARB_RR_EN
    // On a tie the port that did not win last time is granted
    always_comb begin
        if (&i_req) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end else begin
            o_grant = i_req;
        end
    end
`else
    always_comb begin
        o_grant = i_req[0] ? 2'b01 : i_req;
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between two valid/ready requesters.
// Define ALU_ARB_RR_EN for round-robin ties (default: port 0 priority).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req0Valid,
    input  logic             Req1Valid,
    output logic             Req0Ready,
    output logic             Req1Ready,
    input  logic [31:0]      Req0OpA,
    input  logic [31:0]      Req0OpB,
    input  logic [31:0]      Req1OpA,
    input  logic [31:0]      Req1OpB,
    input  logic [3:0]       Req0Sel,
    input  logic [3:0]       Req1Sel,
    output logic             Rsp0Valid,
    output logic             Rsp1Valid,
    input  logic             Rsp0Ready,
    input  logic             Rsp1Ready,
    output logic [31:0]      Rsp0Result,
    output logic [31:0]      Rsp1Result,
    output logic [2:0]       Rsp0Flags,
    output logic [2:0]       Rsp1Flags,
    output logic [31:0]      AluOperandA,
    output logic [31:0]      AluOperandB,
    output logic [3:0]       AluSel,
    input  logic [31:0]      AluResult,
    input  logic             AluOverflow,
    input  logic             AluEqual,
    input  logic             AluCarry,
    output logic             Busy,
    output logic [CNT_W-1:0] OpCount
);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_opa;
    logic [31:0]        r_opb;
    logic [3:0]         r_sel;
    logic               r_gid;
    logic [31:0]        r_result;
    logic [2:0]         r_flags;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         w_grant;
    logic               w_idle;
    logic               w_acc;
    logic               w_done;
    logic [31:0]        w_opa;
    logic [31:0]        w_opb;
    logic [3:0]         w_sel;

`ifdef ALU_ARB_RR_EN
    logic               r_last;

    rr_arb2 u_arb (
        .i_req   ({Req1Valid, Req0Valid}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_done) begin
            r_last <= r_gid;
        end
    end
`else
    rr_arb2 u_arb (
        .i_req   ({Req1Valid, Req0Valid}),
        .o_grant (w_grant)
    );
`endif

    assign w_idle = (r_state == IDLE) & ~reset;
    assign w_acc  = w_idle & |w_grant;
    assign w_done = (r_state == RESP) & (r_gid ? Rsp1Ready : Rsp0Ready);
    assign w_opa  = w_grant[1] ? Req1OpA : Req0OpA;
    assign w_opb  = w_grant[1] ? Req1OpB : Req0OpB;
    assign w_sel  = w_grant[1] ? Req1Sel : Req0Sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_acc) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // HOLD is remapped to PASSB of zero so the ALU output stays defined
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opa <= '0;
            r_opb <= '0;
            r_sel <= ALU_PASSB;
            r_gid <= 1'b0;
        end else if (w_acc) begin
            r_opa <= w_opa;
            r_gid <= w_grant[1];
            if (w_sel == ALU_HOLD) begin
                r_opb <= '0;
                r_sel <= ALU_PASSB;
            end else begin
                r_opb <= w_opb;
                r_sel <= w_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= '0;
            r_cnt    <= '0;
        end else begin
            if (r_state == EXEC) begin
                r_result <= AluResult;
                r_flags  <= {AluOverflow, AluEqual, AluCarry};
            end
            if (w_done) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Req0Ready   = w_idle & w_grant[0];
    assign Req1Ready   = w_idle & w_grant[1];
    assign Rsp0Valid   = (r_state == RESP) & ~r_gid;
    assign Rsp1Valid   = (r_state == RESP) & r_gid;
    assign Rsp0Result  = r_result;
    assign Rsp1Result  = r_result;
    assign Rsp0Flags   = r_flags;
    assign Rsp1Flags   = r_flags;
    assign AluOperandA = r_opa;
    assign AluOperandB = r_opb;
    assign AluSel      = r_sel;
    assign Busy        = (r_state != IDLE);
    assign OpCount     = r_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model;
// a second CNT_W=2 instance checks the counter wrap.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Req0Valid = 0, Req1Valid = 0;
    logic        Req0Ready, Req1Ready;
    logic [31:0] Req0OpA = 0, Req0OpB = 0, Req1OpA = 0, Req1OpB = 0;
    logic [3:0]  Req0Sel = 0, Req1Sel = 0;
    logic        Rsp0Valid, Rsp1Valid;
    logic        Rsp0Ready = 0, Rsp1Ready = 0;
    logic [31:0] Rsp0Result, Rsp1Result;
    logic [2:0]  Rsp0Flags, Rsp1Flags;
    logic [31:0] AluOperandA, AluOperandB;
    logic [3:0]  AluSel;
    logic [31:0] AluResult;
    logic        AluOverflow, AluEqual, AluCarry;
    logic        Busy;
    logic [15:0] OpCount;

    logic        d2_r0rdy, d2_r1rdy, d2_s0v, d2_s1v, d2_busy;
    logic [31:0] d2_s0r, d2_s1r, d2_opa, d2_opb;
    logic [2:0]  d2_s0f, d2_s1f;
    logic [3:0]  d2_sel;
    logic [1:0]  d2_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
        .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
        .Req0OpA(Req0OpA), .Req0OpB(Req0OpB),
        .Req1OpA(Req1OpA), .Req1OpB(Req1OpB),
        .Req0Sel(Req0Sel), .Req1Sel(Req1Sel),
        .Rsp0Valid(Rsp0Valid), .Rsp1Valid(Rsp1Valid),
        .Rsp0Ready(Rsp0Ready), .Rsp1Ready(Rsp1Ready),
        .Rsp0Result(Rsp0Result), .Rsp1Result(Rsp1Result),
        .Rsp0Flags(Rsp0Flags), .Rsp1Flags(Rsp1Flags),
        .AluOperandA(AluOperandA), .AluOperandB(AluOperandB),
        .AluSel(AluSel), .AluResult(AluResult),
        .AluOverflow(AluOverflow), .AluEqual(AluEqual),
        .AluCarry(AluCarry), .Busy(Busy), .OpCount(OpCount)
    );

    alu_arbiter #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
        .Req0Ready(d2_r0rdy), .Req1Ready(d2_r1rdy),
        .Req0OpA(Req0OpA), .Req0OpB(Req0OpB),
        .Req1OpA(Req1OpA), .Req1OpB(Req1OpB),
        .Req0Sel(Req0Sel), .Req1Sel(Req1Sel),
        .Rsp0Valid(d2_s0v), .Rsp1Valid(d2_s1v),
        .Rsp0Ready(Rsp0Ready), .Rsp1Ready(Rsp1Ready),
        .Rsp0Result(d2_s0r), .Rsp1Result(d2_s1r),
        .Rsp0Flags(d2_s0f), .Rsp1Flags(d2_s1f),
        .AluOperandA(d2_opa), .AluOperandB(d2_opb),
        .AluSel(d2_sel), .AluResult(AluResult),
        .AluOverflow(AluOverflow), .AluEqual(AluEqual),
        .AluCarry(AluCarry), .Busy(d2_busy), .OpCount(d2_cnt)
    );

    // Behavioural ALU driven by the arbiter's registered inputs
    always_comb begin
        logic [32:0] t;
        t = '0;
        AluResult   = '0;
        AluCarry    = 1'b0;
        AluOverflow = 1'b0;
        AluEqual    = (AluOperandA == AluOperandB);
        case (AluSel)
            4'b0001: begin
                t = {1'b0, AluOperandA} + {1'b0, AluOperandB};
                AluResult = t[31:0];
                AluCarry  = t[32];
                AluOverflow = (AluOperandA[31] == AluOperandB[31]) &&
                              (t[31] != AluOperandA[31]);
            end
            4'b0010: begin
                AluResult = AluOperandA - AluOperandB;
                AluCarry  = (AluOperandA < AluOperandB);
                AluOverflow = (AluOperandA[31] != AluOperandB[31]) &&
                              (AluResult[31] != AluOperandA[31]);
            end
            4'b0101: AluResult = AluOperandA & AluOperandB;
            4'b0110: AluResult = AluOperandA | AluOperandB;
            4'b0111: AluResult = ~AluOperandA;
            4'b1000: AluResult = AluOperandA ^ AluOperandB;
            4'b1001: AluResult = AluOperandA << AluOperandB[4:0];
            4'b1011: AluResult = AluOperandB;
            default: AluResult = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        Req0Valid = 1'b1;
        Req1Valid = 1'b0;
        Rsp0Ready = 1'b0;
        Rsp1Ready = 1'b0;
        #1;
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_rdy0"}, Req0Ready, 0);
        chk({tag, "_alusel"}, AluSel, 32'hB);
        chk({tag, "_opa"}, AluOperandA, 0);
        chk({tag, "_opb"}, AluOperandB, 0);
        chk({tag, "_rspv"}, {Rsp1Valid, Rsp0Valid}, 0);
        chk({tag, "_res"}, Rsp0Result, 0);
        chk({tag, "_flg"}, Rsp1Flags, 0);
        chk({tag, "_cnt"}, OpCount, 0);
        Req0Valid = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Single request from one port, response consumed in its first cycle
    task automatic do_op(input string tag, input logic port,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic [31:0] er,
                         input logic [2:0] ef);
        if (port) begin
            Req1Valid = 1; Req1OpA = a; Req1OpB = b; Req1Sel = sel;
        end else begin
            Req0Valid = 1; Req0OpA = a; Req0OpB = b; Req0Sel = sel;
        end
        #1;
        chk({tag, "_rdy"}, port ? Req1Ready : Req0Ready, 1);
        chk({tag, "_nrdy"}, port ? Req0Ready : Req1Ready, 0);
        @(negedge clk);
        Req0Valid = 0;
        Req1Valid = 0;
        #1;
        chk({tag, "_busy"}, Busy, 1);
        chk({tag, "_early"}, {Rsp1Valid, Rsp0Valid}, 0);
        chk({tag, "_alusel"}, AluSel, (sel == 4'b0000) ? 4'b1011 : sel);
        chk({tag, "_alub"}, AluOperandB, (sel == 4'b0000) ? 0 : b);
        @(negedge clk);
        #1;
        chk({tag, "_rspv"}, {Rsp1Valid, Rsp0Valid}, port ? 2 : 1);
        chk({tag, "_res"}, port ? Rsp1Result : Rsp0Result, er);
        chk({tag, "_flg"}, port ? Rsp1Flags : Rsp0Flags, ef);
        if (port) Rsp1Ready = 1; else Rsp0Ready = 1;
        @(negedge clk);
        Rsp0Ready = 0;
        Rsp1Ready = 0;
        exp_cnt++;
        #1;
        chk({tag, "_idle"}, Busy, 0);
        chk({tag, "_cnt"}, OpCount, exp_cnt[15:0]);
        chk({tag, "_cnt2"}, d2_cnt, exp_cnt[1:0]);
    endtask

    initial begin
        int ep;
        do_reset("rst0");

        do_op("add", 1'b0, 32'd5, 32'd3, 4'b0001, 32'd8, 3'b000);

        // Both ports valid every cycle
        do_reset("rst1");
        Req0Valid = 1; Req0OpA = 32'h7FFF_FFFF; Req0OpB = 1; Req0Sel = 4'b0001;
        Req1Valid = 1; Req1OpA = 9; Req1OpB = 9; Req1Sel = 4'b0010;
        Rsp0Ready = 1; Rsp1Ready = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            ep = k % 2;
`else
            ep = 0;
`endif
            #1;
            chk("tie_rdy", {Req1Ready, Req0Ready}, (ep == 1) ? 2 : 1);
            @(negedge clk);
            #1;
            chk("tie_exec", {Req1Ready, Req0Ready, Busy}, 1);
            @(negedge clk);
            #1;
            chk("tie_rspv", {Rsp1Valid, Rsp0Valid}, (ep == 1) ? 2 : 1);
            chk("tie_res", (ep == 1) ? Rsp1Result : Rsp0Result,
                (ep == 1) ? 32'h0 : 32'h8000_0000);
            chk("tie_flg", (ep == 1) ? Rsp1Flags : Rsp0Flags,
                (ep == 1) ? 3'b010 : 3'b100);
            @(negedge clk);
            exp_cnt++;
            #1;
            chk("tie_cnt", OpCount, exp_cnt[15:0]);
            #1;
        end
        Req0Valid = 0; Req1Valid = 0;
        Rsp0Ready = 0; Rsp1Ready = 0;
        @(negedge clk);

        // Response back-pressure while the other port waits
        Req1Valid = 1; Req1OpA = 9; Req1OpB = 9; Req1Sel = 4'b0010;
        #1;
        chk("bp_rdy", Req1Ready, 1);
        @(negedge clk);
        Req1Valid = 0;
        Req0Valid = 1; Req0OpA = 1; Req0OpB = 1; Req0Sel = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rspv", {Rsp1Valid, Rsp0Valid}, 2);
            chk("bp_res", Rsp1Result, 0);
            chk("bp_flg", Rsp1Flags, 3'b010);
            chk("bp_rdy", {Req1Ready, Req0Ready}, 0);
            chk("bp_busy", Busy, 1);
            @(negedge clk);
        end
        Req0Valid = 0;
        Rsp1Ready = 1;
        @(negedge clk);
        Rsp1Ready = 0;
        exp_cnt++;
        #1;
        chk("bp_cnt", OpCount, exp_cnt[15:0]);
        chk("bp_idle", {Busy, Rsp1Valid}, 0);
        @(negedge clk);

        // HOLD select is remapped to PASSB of zero
        do_op("hold", 1'b0, 32'd5, 32'd7, 4'b0000, 32'd0, 3'b000);

        // Reset in EXEC aborts the operation
        do_reset("rst2");
        Req0Valid = 1; Req0OpA = 1; Req0OpB = 2; Req0Sel = 4'b0001;
        @(negedge clk);
        Req0Valid = 0;
        Rsp0Ready = 1;
        #1;
        chk("ab_exec", Busy, 1);
        reset = 1;
        #1;
        chk("ab_busy", Busy, 0);
        chk("ab_alusel", AluSel, 32'hB);
        chk("ab_opa", AluOperandA, 0);
        chk("ab_cnt", OpCount, 0);
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("ab_norsp", {Rsp1Valid, Rsp0Valid, Busy}, 0);
            chk("ab_cnt", OpCount, 0);
        end
        Rsp0Ready = 0;

        // Four completions: the 2-bit counter wraps 3 -> 0
        do_op("w1", 1'b0, 32'd1, 32'd1, 4'b0001, 32'd2, 3'b010);
        do_op("w2", 1'b1, 32'hF0, 32'h0F, 4'b0110, 32'hFF, 3'b000);
        do_op("w3", 1'b0, 32'd3, 32'd2, 4'b1001, 32'd12, 3'b000);
        do_op("w4", 1'b1, 32'd2, 32'd3, 4'b0010, 32'hFFFF_FFFF, 3'b001);
        chk("wrap", d2_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
